// File: rtl/mips_cpu_bus_port.sv
// ============================================================================
// mips_cpu_bus_port : round-robin Avalon-MM master for the multicycle MIPS core
// Optional waitrequest timeout: define MIPS_CPU_BUS_PORT_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module mips_cpu_bus_port #(
  parameter int N_CH           = 2,
  parameter int SWAP_ENDIAN    = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [N_CH-1:0]      req_write,
  input  logic [2*N_CH-1:0]    req_size,
  input  logic [N_CH-1:0]      req_signed,
  input  logic [32*N_CH-1:0]   req_addr,
  input  logic [32*N_CH-1:0]   req_wdata,
  output logic [N_CH-1:0]      req_ready,
  output logic [N_CH-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_error,
  output logic                 busy,
  output logic [31:0]          address,
  output logic                 read,
  output logic                 write,
  input  logic                 waitrequest,
  output logic [31:0]          writedata,
  output logic [3:0]           byteenable,
  input  logic [31:0]          readdata
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q, owner_q;
  logic            write_q, signed_q, err_q, rd_q, wr_q, rsp_error_q;
  logic [1:0]      size_q, off_q;
  logic [N_CH-1:0] req_ready_q, rsp_valid_q;
  logic [31:0]     rsp_rdata_q, address_q, writedata_q;
  logic [3:0]      byteenable_q;

  // Round-robin grant: first valid channel at or after the pointer
  logic          gnt_found;
  logic [IW-1:0] gnt_idx, ptr_d;
  int            c, gi;
  logic          sel_write, sel_signed, misaligned;
  logic [1:0]    sel_size, sel_off;
  logic [31:0]   sel_addr, sel_wdata, wd_d;
  logic [3:0]    be_d;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    for (int i = 0; i < N_CH; i++) begin
      c = int'(ptr_q) + i;
      if (c >= N_CH) c = c - N_CH;
      if (!gnt_found && req_valid[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(c);
      end
    end
  end

  always_comb begin
    gi         = int'(gnt_idx);
    sel_write  = req_write[gi];
    sel_signed = req_signed[gi];
    sel_size   = req_size[2*gi +: 2];
    sel_addr   = req_addr[32*gi +: 32];
    sel_wdata  = req_wdata[32*gi +: 32];
    sel_off    = sel_addr[1:0];
    ptr_d      = (gi + 1 >= N_CH) ? '0 : IW'(gi + 1);
    misaligned = (sel_size == 2'b11) ||
                 (sel_size == 2'b01 && sel_off[0]) ||
                 (sel_size == 2'b10 && sel_off != 2'b00);
    be_d       = 4'b1111;
    wd_d       = sel_wdata;
    case (sel_size)
      2'b00: begin
        be_d = 4'b0001 << sel_off;
        wd_d = {4{sel_wdata[7:0]}};
      end
      2'b01: begin
        be_d = 4'b0011 << sel_off;
        wd_d = (SWAP_ENDIAN != 0) ? {2{sel_wdata[7:0], sel_wdata[15:8]}}
                                  : {2{sel_wdata[15:0]}};
      end
      default: begin
        be_d = 4'b1111;
        wd_d = (SWAP_ENDIAN != 0) ? {sel_wdata[7:0], sel_wdata[15:8],
                                     sel_wdata[23:16], sel_wdata[31:24]}
                                  : sel_wdata;
      end
    endcase
  end

  // Load formatting from the live bus data, registered on completion
  logic [7:0]  lane [4];
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_d;

  always_comb begin
    for (int n = 0; n < 4; n++) lane[n] = readdata[8*n +: 8];
    ld_b = lane[off_q];
    ld_h = (SWAP_ENDIAN != 0) ? {lane[{off_q[1], 1'b0}], lane[{off_q[1], 1'b1}]}
                              : {lane[{off_q[1], 1'b1}], lane[{off_q[1], 1'b0}]};
    case (size_q)
      2'b00:   ld_d = signed_q ? {{24{ld_b[7]}}, ld_b} : {24'b0, ld_b};
      2'b01:   ld_d = signed_q ? {{16{ld_h[15]}}, ld_h} : {16'b0, ld_h};
      default: ld_d = (SWAP_ENDIAN != 0) ? {lane[0], lane[1], lane[2], lane[3]}
                                         : readdata;
    endcase
  end

`ifdef MIPS_CPU_BUS_PORT_TIMEOUT_EN
  logic [15:0] tmo_q;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      write_q      <= 1'b0;
      signed_q     <= 1'b0;
      err_q        <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
`ifdef MIPS_CPU_BUS_PORT_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      req_ready_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            req_ready_q[gnt_idx] <= 1'b1;
            ptr_q        <= ptr_d;
            owner_q      <= gnt_idx;
            write_q      <= sel_write;
            signed_q     <= sel_signed;
            size_q       <= sel_size;
            off_q        <= sel_off;
            err_q        <= misaligned;
            address_q    <= {sel_addr[31:2], 2'b00};
            byteenable_q <= be_d;
            writedata_q  <= wd_d;
            state_q      <= misaligned ? S_RESP : S_ACCESS;
`ifdef MIPS_CPU_BUS_PORT_TIMEOUT_EN
            tmo_q        <= '0;
`endif
          end
        end
        S_ACCESS: begin
          if (!rd_q && !wr_q) begin
            rd_q <= !write_q;
            wr_q <= write_q;
          end else if (!waitrequest) begin
            rd_q                 <= 1'b0;
            wr_q                 <= 1'b0;
            rsp_rdata_q          <= write_q ? 32'd0 : ld_d;
            rsp_error_q          <= 1'b0;
            rsp_valid_q[owner_q] <= 1'b1;
            state_q              <= S_RESP;
          end
`ifdef MIPS_CPU_BUS_PORT_TIMEOUT_EN
          else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
            rd_q                 <= 1'b0;
            wr_q                 <= 1'b0;
            rsp_rdata_q          <= '0;
            rsp_error_q          <= 1'b1;
            rsp_valid_q[owner_q] <= 1'b1;
            state_q              <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
`endif
        end
        S_RESP: begin
          // Error grants arrive here with no pulse yet; bus completions already pulsed
          if (|rsp_valid_q) begin
            rsp_valid_q <= '0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            state_q     <= S_IDLE;
          end else begin
            rsp_valid_q[owner_q] <= 1'b1;
            rsp_error_q          <= err_q;
            rsp_rdata_q          <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_error  = rsp_error_q;
  assign busy       = (state_q != S_IDLE);
  assign address    = address_q;
  assign read       = rd_q;
  assign write      = wr_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_bus_port.sv
// ============================================================================
// tb_mips_cpu_bus_port : scoreboard bench for mips_cpu_bus_port. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_cpu_bus_port;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid, req_write, req_signed;
  logic [2*N-1:0]  req_size;
  logic [32*N-1:0] req_addr, req_wdata;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [31:0]     rsp_rdata, address, writedata;
  logic            rsp_error, busy, read, write;
  logic            waitrequest = 1'b0;
  logic [3:0]      byteenable;
  logic [31:0]     readdata = 32'd0;

  logic        tb_valid  [N];
  logic        tb_write  [N];
  logic        tb_signed [N];
  logic [1:0]  tb_size   [N];
  logic [31:0] tb_addr   [N];
  logic [31:0] tb_wdata  [N];

  always_comb begin
    req_valid = '0; req_write = '0; req_signed = '0;
    req_size = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = tb_valid[i];
      req_write[i]         = tb_write[i];
      req_signed[i]        = tb_signed[i];
      req_size[2*i +: 2]   = tb_size[i];
      req_addr[32*i +: 32] = tb_addr[i];
      req_wdata[32*i +: 32] = tb_wdata[i];
    end
  end

  mips_cpu_bus_port #(.N_CH(N), .SWAP_ENDIAN(1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy), .address(address), .read(read),
    .write(write), .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ch; logic [31:0] rdata; logic err; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic wr; } beat_t;
  rsp_t  rsp_q[$];
  beat_t bus_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Response monitor
  always @(negedge clk) begin
    rsp_t e;
    logic [N-1:0] ev;
    if (|rsp_valid) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = rsp_q.pop_front();
        ev = '0;
        ev[e.ch] = 1'b1;
        chk("rsp_owner", 64'(rsp_valid), 64'(ev));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_error", 64'(rsp_error), 64'(e.err));
        if (e.cyc >= 0) chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Avalon slave model with programmable wait states
  int          wait_n = 0;
  int          beat_cnt = 0;
  logic [31:0] slv_rdata = 32'd0;
  logic [69:0] hold;

  always @(negedge clk) begin
    beat_t b;
    logic [31:0] m;
    if (read || write) begin
      if (beat_cnt == 0) hold = {address, byteenable, writedata, read, write};
      else chk("bus_stable", 64'({address, byteenable, read, write} ^ {hold[69:34], hold[1:0]}) |
                             64'(writedata ^ hold[33:2]), 64'd0);
      if (beat_cnt < wait_n) begin
        waitrequest = 1'b1;
        readdata    = 32'hDEADDEAD;
        beat_cnt++;
      end else begin
        waitrequest = 1'b0;
        readdata    = slv_rdata;
        beat_cnt    = 0;
        if (bus_q.size() == 0) begin
          chk("unexpected_beat", 64'(address), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          b = bus_q.pop_front();
          chk("bus_addr", 64'(address), 64'(b.addr));
          chk("bus_be", 64'(byteenable), 64'(b.be));
          chk("bus_strobes", 64'({read, write}), 64'({!b.wr, b.wr}));
          if (b.wr) begin
            m = {{8{b.be[3]}}, {8{b.be[2]}}, {8{b.be[1]}}, {8{b.be[0]}}};
            chk("bus_wdata", 64'(writedata & m), 64'(b.wdata & m));
          end
        end
      end
    end else begin
      waitrequest = 1'b0;
      beat_cnt    = 0;
    end
  end

  task automatic set_req(input int ch, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd);
    tb_write[ch] = wr; tb_size[ch] = sz; tb_signed[ch] = sg;
    tb_addr[ch] = addr; tb_wdata[ch] = wd;
  endtask

  task automatic drain();
    int guard = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0 || busy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) fail_now("drain");
  endtask

  task automatic issue(input int ch, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                       input int waits, input logic [31:0] exp_rd, input logic exp_err,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd, input int lat);
    int t0;
    int guard;
    rsp_t r;
    beat_t b;
    slv_rdata = rd;
    wait_n    = waits;
    @(posedge clk); #1;
    t0 = cyc;
    r.ch = ch; r.rdata = exp_rd; r.err = exp_err; r.cyc = t0 + lat;
    rsp_q.push_back(r);
    if (!exp_err) begin
      b.addr = {addr[31:2], 2'b00}; b.be = exp_be; b.wdata = exp_wd; b.wr = wr;
      bus_q.push_back(b);
    end
    set_req(ch, wr, sz, sg, addr, wd);
    tb_valid[ch] = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!req_ready[ch] && guard < 20);
    chk("ready_cycle", 64'(cyc), 64'(t0 + 1));
    chk("busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("ready_pulse", 64'(req_ready[ch]), 64'd0);
    @(posedge clk); #1;
    tb_valid[ch] = 1'b0;
    drain();
  endtask

  task automatic drive_ch(input int ch, input int n);
    int got = 0;
    int guard = 0;
    tb_valid[ch] = 1'b1;
    while (got < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (req_ready[ch]) begin
        got++;
        @(negedge clk);
        chk("arb_ready_pulse", 64'(req_ready[ch]), 64'd0);
      end
    end
    if (got < n) fail_now("arb_grant");
    @(posedge clk); #1;
    tb_valid[ch] = 1'b0;
  endtask

  initial begin
    rsp_t r;
    beat_t b;
    int guard;
    for (int i = 0; i < N; i++) begin
      tb_valid[i] = 1'b0;
      set_req(i, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 64'({req_ready, rsp_valid, rsp_error, busy, read, write, byteenable}), 64'd0);
    chk("rst_data", {rsp_rdata, address}, 64'd0);
    chk("rst_wdata", 64'(writedata), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    //    ch wr    sz     sg    addr       wdata        readdata     w  exp_rdata     err   be       exp_wdata    lat
    issue(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h78563412, 0, 32'h12345678, 1'b0, 4'b1111, 32'h0,       3);
    issue(1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h80000000, 0, 32'hFFFFFF80, 1'b0, 4'b1000, 32'h0,       3);
    issue(1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h80000000, 0, 32'h00000080, 1'b0, 4'b1000, 32'h0,       3);
    issue(0, 1'b0, 2'b00, 1'b1, 32'h100, 32'h0,        32'h0000007F, 0, 32'h0000007F, 1'b0, 4'b0001, 32'h0,       3);
    issue(0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 32'h0,        0, 32'h0,        1'b0, 4'b1100, 32'hCDAB0000, 3);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h104, 32'h11223344, 32'h0,        0, 32'h0,        1'b0, 4'b1111, 32'h44332211, 3);
    issue(1, 1'b1, 2'b00, 1'b0, 32'h105, 32'h000000A5, 32'h0,        0, 32'h0,        1'b0, 4'b0010, 32'h0000A500, 3);
    issue(0, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        32'h7F800000, 0, 32'hFFFF807F, 1'b0, 4'b1100, 32'h0,       3);
    issue(1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0,        32'h00001234, 0, 32'h00003412, 1'b0, 4'b0011, 32'h0,       3);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        32'h78563412, 0, 32'h0,        1'b1, 4'b0000, 32'h0,       2);
    issue(1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        32'h78563412, 0, 32'h0,        1'b1, 4'b0000, 32'h0,       2);
    issue(0, 1'b1, 2'b01, 1'b0, 32'h103, 32'h1234,     32'h0,        0, 32'h0,        1'b1, 4'b0000, 32'h0,       2);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h78563412, 3, 32'h12345678, 1'b0, 4'b1111, 32'h0,       6);
    issue(1, 1'b1, 2'b10, 1'b0, 32'h108, 32'hDEADBEEF, 32'h0,        2, 32'h0,        1'b0, 4'b1111, 32'hEFBEADDE, 5);

    // Reset while the read is stalled: the response must never appear
    wait_n = 1000;
    @(posedge clk); #1;
    set_req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    tb_valid[0] = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!req_ready[0] && guard < 20);
    @(posedge clk); #1;
    tb_valid[0] = 1'b0;
    guard = 0;
    while (!read && guard < 20) begin @(negedge clk); guard++; end
    chk("stall_read", 64'(read), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_read", 64'(read), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    wait_n = 0;

    // Two channels contending: strict alternation starting from channel 0
    slv_rdata = 32'h78563412;
    for (int k = 0; k < 2; k++) begin
      r.ch = 0; r.rdata = 32'h12345678; r.err = 1'b0; r.cyc = -1; rsp_q.push_back(r);
      b.addr = 32'h200; b.be = 4'b1111; b.wdata = 32'h0; b.wr = 1'b0; bus_q.push_back(b);
      r.ch = 1; r.rdata = 32'h00000034; r.err = 1'b0; r.cyc = -1; rsp_q.push_back(r);
      b.addr = 32'h300; b.be = 4'b0010; b.wdata = 32'h0; b.wr = 1'b0; bus_q.push_back(b);
    end
    set_req(0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    set_req(1, 1'b0, 2'b00, 1'b0, 32'h301, 32'h0);
    @(posedge clk); #1;
    fork
      drive_ch(0, 2);
      drive_ch(1, 2);
    join
    drain();

`ifdef MIPS_CPU_BUS_PORT_TIMEOUT_EN
    // waitrequest stuck high: four stalled cycles then an error response
    wait_n = 1000;
    issue(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h78563412, 1000, 32'h0, 1'b1, 4'b1111, 32'h0, 6);
    wait_n = 0;
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(rsp_q.size() + bus_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
